// File: rtl/pwm_capture.sv
// pwm_capture
//   Measures high time and rising-to-rising period of an asynchronous PWM
//   input, in clk cycles (50 MHz: 50_000 = 1 ms, 1_000_000 = 20 ms).
//
// Parameters
//   TIMEOUT    : cycles without a qualifying rising edge before the signal
//                is declared lost (2..1_048_575).
//   FILTER_LEN : glitch-filter stability length in cycles (1..15), only
//                used when PWM_CAP_FILTER_EN is defined.
//
// Ports
//   clk         : 50 MHz clock
//   rst_n       : asynchronous active-low reset
//   pwm_in      : asynchronous PWM input
//   duty_meas   : high time of the last complete period
//   period_meas : period of the last complete period
//   meas_valid  : one-cycle pulse when duty_meas/period_meas update
//   sig_lost    : level, no valid period within TIMEOUT cycles
//
// Build option
//   PWM_CAP_FILTER_EN : inserts a FILTER_LEN-cycle glitch filter after the
//                       synchronizer. Undefined by default (no filter).

module pwm_capture #(
  parameter int unsigned TIMEOUT    = 1_000_000,
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwm_in,
  output logic [19:0] duty_meas,
  output logic [19:0] period_meas,
  output logic        meas_valid,
  output logic        sig_lost
);

  localparam logic [19:0] TIMEOUT_CNT = 20'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  state_t      state;
  logic [19:0] per_cnt;
  logic [19:0] high_cnt;

  // Synchronizer resets high so a pin already high at reset release does
  // not produce a spurious rising edge.
  logic sync_q1;
  logic sync_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= pwm_in;
      sync_q2 <= sync_q1;
    end
  end

  logic level;

`ifdef PWM_CAP_FILTER_EN
  localparam logic [3:0] FILT_LAST = 4'(FILTER_LEN - 1);

  logic [3:0] filt_cnt;
  logic       filt_level;

  // The filtered level follows sync_q2 only after it has differed for
  // FILTER_LEN consecutive cycles; both edges are delayed equally, so
  // measured widths are unchanged for clean input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_level <= 1'b1;
      filt_cnt   <= '0;
    end else if (sync_q2 != filt_level) begin
      if (filt_cnt == FILT_LAST) begin
        filt_level <= sync_q2;
        filt_cnt   <= '0;
      end else begin
        filt_cnt <= filt_cnt + 4'd1;
      end
    end else begin
      filt_cnt <= '0;
    end
  end

  assign level = filt_level;
`else
  logic [31:0] unused_filter_len;
  assign unused_filter_len = FILTER_LEN;
  assign level = sync_q2;
`endif

  logic level_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_prev <= 1'b1;
    end else begin
      level_prev <= level;
    end
  end

  logic rise;
  logic fall;
  logic timed_out;

  assign rise      = level & ~level_prev;
  assign fall      = ~level & level_prev;
  // per_cnt never exceeds TIMEOUT: reaching it forces the return to IDLE,
  // which also wins over a rising edge seen in the same cycle.
  assign timed_out = (per_cnt == TIMEOUT_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      per_cnt     <= '0;
      high_cnt    <= '0;
      duty_meas   <= '0;
      period_meas <= '0;
      meas_valid  <= 1'b0;
      sig_lost    <= 1'b1;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        IDLE: begin
          // First rise only starts timing; this partial period is dropped.
          if (rise) begin
            per_cnt  <= 20'd1;
            high_cnt <= 20'd1;
            state    <= HIGH;
          end
        end

        HIGH: begin
          if (timed_out) begin
            sig_lost <= 1'b1;
            per_cnt  <= '0;
            high_cnt <= '0;
            state    <= IDLE;
          end else begin
            per_cnt <= per_cnt + 20'd1;
            if (fall) begin
              state <= LOW;
            end else begin
              high_cnt <= high_cnt + 20'd1;
            end
          end
        end

        LOW: begin
          if (timed_out) begin
            sig_lost <= 1'b1;
            per_cnt  <= '0;
            high_cnt <= '0;
            state    <= IDLE;
          end else if (rise) begin
            period_meas <= per_cnt;
            duty_meas   <= high_cnt;
            meas_valid  <= 1'b1;
            sig_lost    <= 1'b0;
            per_cnt     <= 20'd1;
            high_cnt    <= 20'd1;
            state       <= HIGH;
          end else begin
            per_cnt <= per_cnt + 20'd1;
          end
        end

        default: begin
          per_cnt  <= '0;
          high_cnt <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture
//   Directed bench for pwm_capture with a shortened TIMEOUT so every corner
//   case fits in a short run. A monitor logs each meas_valid pulse (values
//   and cycle); a vector table covers steady waveforms, and hand-written
//   sequences cover reset, timeout, latency and glitch behaviour.

module tb_pwm_capture;

  localparam int TO = 200;
  localparam int FL = 4;
`ifdef PWM_CAP_FILTER_EN
  localparam int LAT = 3 + FL;
`else
  localparam int LAT = 3;
`endif

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        pwm_in = 1'b1;
  logic [19:0] duty_meas;
  logic [19:0] period_meas;
  logic        meas_valid;
  logic        sig_lost;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  int duty_q[$];
  int period_q[$];
  int vcyc_q[$];

  pwm_capture #(
    .TIMEOUT   (TO),
    .FILTER_LEN(FL)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .duty_meas  (duty_meas),
    .period_meas(period_meas),
    .meas_valid (meas_valid),
    .sig_lost   (sig_lost)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (meas_valid) begin
      duty_q.push_back(int'(duty_meas));
      period_q.push_back(int'(period_meas));
      vcyc_q.push_back(cyc);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic period(input int h, input int p);
    pwm_in = 1'b1;
    tick(h);
    pwm_in = 1'b0;
    tick(p - h);
  endtask

  task automatic do_reset();
    pwm_in = 1'b1;
    rst_n  = 1'b0;
    tick(3);
    rst_n  = 1'b1;
    tick(2);
    pwm_in = 1'b0;
    tick(8);
  endtask

  task automatic wait_lost(output int at_cyc);
    at_cyc = -1;
    for (int k = 0; k < 3 * TO; k++) begin
      tick(1);
      if (sig_lost) begin
        at_cyc = cyc;
        break;
      end
    end
  endtask

  typedef struct {
    int h;
    int p;
    int n;
    int exp_duty;
    int exp_per;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int base;
    int rc;
    int v;
    int lost_at;

    vecs[0] = '{15, 100, 3, 15, 100};
    vecs[1] = '{1, 10, 3, 1, 10};
    vecs[2] = '{9, 10, 3, 9, 10};
    vecs[3] = '{1, 2, 4, 1, 2};
    vecs[4] = '{50, 199, 2, 50, 199};
    vecs[5] = '{198, 199, 2, 198, 199};

    // Reset with the pin held high: reset values, then no false edge.
    pwm_in = 1'b1;
    rst_n  = 1'b0;
    tick(2);
    check("rst_duty", int'(duty_meas), 0);
    check("rst_period", int'(period_meas), 0);
    check("rst_valid", int'(meas_valid), 0);
    check("rst_lost", int'(sig_lost), 1);
    rst_n = 1'b1;
    tick(20);
    check("no_false_rise_count", duty_q.size(), 0);
    check("no_false_rise_lost", int'(sig_lost), 1);

    // First period discarded; latency and sig_lost 1->0 at the first valid.
    pwm_in = 1'b0;
    tick(8);
    period(15, 100);
    check("first_period_no_valid", duty_q.size(), 0);
    pwm_in = 1'b1;
    rc = cyc;
    tick(LAT - 1);
    check("pre_valid_low", int'(meas_valid), 0);
    check("pre_valid_lost", int'(sig_lost), 1);
    tick(1);
    check("valid_pulse", int'(meas_valid), 1);
    check("valid_lost_clear", int'(sig_lost), 0);
    check("valid_duty", int'(duty_meas), 15);
    check("valid_period", int'(period_meas), 100);
    tick(1);
    check("valid_one_cycle", int'(meas_valid), 0);
    tick(15 - (LAT + 1));
    pwm_in = 1'b0;
    tick(85);
    check("latency", vcyc_q[0] - rc, LAT);

    // Stuck low: sig_lost TIMEOUT cycles after the last published rise.
    v = vcyc_q[vcyc_q.size() - 1];
    wait_lost(lost_at);
    check("lost_low_time", lost_at, v + TO);
    check("lost_low_hold_duty", int'(duty_meas), 15);
    check("lost_low_hold_period", int'(period_meas), 100);
    check("lost_low_no_valid", duty_q.size(), 1);

    // Resume: two rises needed for a new measurement.
    period(25, 100);
    period(35, 100);
    check("resume_count", duty_q.size(), 2);
    check("resume_duty", duty_q[1], 25);
    check("resume_lost", int'(sig_lost), 0);

    // Stuck high after the next rise.
    pwm_in = 1'b1;
    tick(LAT + 1);
    v = vcyc_q[vcyc_q.size() - 1];
    check("stuck_high_pub_duty", duty_q[duty_q.size() - 1], 35);
    wait_lost(lost_at);
    check("lost_high_time", lost_at, v + TO);
    check("lost_high_hold_duty", int'(duty_meas), 35);

    // Steady-waveform vector table.
    foreach (vecs[i]) begin
`ifdef PWM_CAP_FILTER_EN
      if (vecs[i].h < FL || vecs[i].p - vecs[i].h < FL) continue;
`endif
      do_reset();
      base = duty_q.size();
      repeat (vecs[i].n) period(vecs[i].h, vecs[i].p);
      pwm_in = 1'b1;
      tick(LAT + 4);
      check($sformatf("vec%0d_count", i), duty_q.size() - base, vecs[i].n);
      if (duty_q.size() > base) begin
        check($sformatf("vec%0d_first_duty", i), duty_q[base], vecs[i].exp_duty);
        check($sformatf("vec%0d_first_period", i), period_q[base], vecs[i].exp_per);
      end
      check($sformatf("vec%0d_last_duty", i), int'(duty_meas), vecs[i].exp_duty);
      check($sformatf("vec%0d_last_period", i), int'(period_meas), vecs[i].exp_per);
      check($sformatf("vec%0d_lost", i), int'(sig_lost), 0);
    end

    // Alternating duty: consecutive pulses report 10, 40, 10, 40.
    do_reset();
    base = duty_q.size();
    period(10, 100);
    period(40, 100);
    period(10, 100);
    period(40, 100);
    pwm_in = 1'b1;
    tick(LAT + 4);
    check("alt_count", duty_q.size() - base, 4);
    if (duty_q.size() >= base + 4) begin
      check("alt_duty0", duty_q[base], 10);
      check("alt_duty1", duty_q[base + 1], 40);
      check("alt_duty2", duty_q[base + 2], 10);
      check("alt_duty3", duty_q[base + 3], 40);
    end

    // Rise on the exact TIMEOUT cycle is a timeout, and that rise is not
    // reused to start the next measurement.
    do_reset();
    base = duty_q.size();
    period(20, 100);
    period(20, 100);
    period(20, TO);
    pwm_in = 1'b1;
    tick(LAT - 1);
    check("edge_to_pre_lost", int'(sig_lost), 0);
    tick(1);
    check("edge_to_lost", int'(sig_lost), 1);
    check("edge_to_no_valid", int'(meas_valid), 0);
    check("edge_to_count", duty_q.size() - base, 2);
    tick(30 - LAT);
    pwm_in = 1'b0;
    tick(70);
    period(45, 100);
    pwm_in = 1'b1;
    tick(LAT + 4);
    check("edge_to_after_count", duty_q.size() - base, 3);
    if (duty_q.size() >= base + 3) begin
      check("edge_to_after_duty", duty_q[base + 2], 45);
      check("edge_to_after_period", period_q[base + 2], 100);
    end

    // Reset mid-HIGH: reset values, then the first valid reports the first
    // full period after release.
    do_reset();
    period(30, 100);
    period(30, 100);
    pwm_in = 1'b1;
    tick(10);
    rst_n = 1'b0;
    tick(1);
    check("midrst_duty", int'(duty_meas), 0);
    check("midrst_period", int'(period_meas), 0);
    check("midrst_valid", int'(meas_valid), 0);
    check("midrst_lost", int'(sig_lost), 1);
    tick(4);
    rst_n = 1'b1;
    tick(15);
    pwm_in = 1'b0;
    tick(70);
    base = duty_q.size();
    period(20, 100);
    period(40, 100);
    pwm_in = 1'b1;
    tick(LAT + 4);
    check("midrst_count", duty_q.size() - base, 2);
    if (duty_q.size() >= base + 2) begin
      check("midrst_first_duty", duty_q[base], 20);
      check("midrst_first_period", period_q[base], 100);
      check("midrst_second_duty", duty_q[base + 1], 40);
    end

    // 3-cycle low glitch inside a 40-cycle high.
    do_reset();
    base = duty_q.size();
    repeat (2) begin
      pwm_in = 1'b1;
      tick(15);
      pwm_in = 1'b0;
      tick(3);
      pwm_in = 1'b1;
      tick(22);
      pwm_in = 1'b0;
      tick(60);
    end
    pwm_in = 1'b1;
    tick(LAT + 4);
`ifdef PWM_CAP_FILTER_EN
    check("glitch_count", duty_q.size() - base, 2);
    if (duty_q.size() > base) begin
      check("glitch_duty", duty_q[base], 40);
      check("glitch_period", period_q[base], 100);
    end
`else
    check("glitch_count", duty_q.size() - base, 4);
    if (duty_q.size() >= base + 2) begin
      check("glitch_duty0", duty_q[base], 15);
      check("glitch_period0", period_q[base], 18);
      check("glitch_duty1", duty_q[base + 1], 22);
      check("glitch_period1", period_q[base + 1], 82);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
